// File: rtl/cmd_pkg.sv
// Shared definitions for the command-handler blocks: arbiter FSM states and
// the byte width used by the PC-facing UART path.
package cmd_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SEND_WAIT = 2'd1,
    ARB_HOLD      = 2'd2
  } arb_state_e;

endpackage : cmd_pkg

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first requester at or above the pointer, with wrap.
// Purely combinational; the owner of the pointer decides when it moves.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_req_o
);

  // Walk downward so the candidate closest to the pointer is written last.
  always_comb begin
    int idx;
    idx       = 0;
    winner_o  = ptr_i;
    any_req_o = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        winner_o = IDX_W'(idx);
      end else begin
        winner_o = winner_o;
      end
    end
  end

endmodule : rr_picker

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter between
// several byte-stream sources, with a stall timeout on a held grant.
module uart_tx_arbiter
  import cmd_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = BYTE_WIDTH,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_vld,
  input  logic                          tx_rdy,
  output logic [$clog2(NUM_REQ)-1:0]    grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  arb_state_e              state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [NUM_REQ-1:0]      req_rdy_q, req_rdy_d;
  logic                    busy_q, busy_d;
  logic                    timeout_err_q, timeout_err_d;

  logic [GW-1:0]           winner;
  logic                    any_req;
  logic                    launch;
  logic [GW-1:0]           launch_idx;
  logic [GW-1:0]           next_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_picker (
    .req_i     (req_vld),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // The owner just served drops to lowest priority.
  assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : grant_q + GW'(1);

  // Next-state, counter and registered-output launch logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    tx_vld_d      = 1'b0;
    req_rdy_d     = {NUM_REQ{1'b0}};
    timeout_err_d = 1'b0;
    launch        = 1'b0;
    launch_idx    = grant_q;

    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          launch     = 1'b1;
          launch_idx = winner;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_SEND_WAIT: begin
        if (tx_rdy && last_q) begin
          state_d = ARB_IDLE;
          ptr_d   = next_ptr;
        end else if (tx_rdy) begin
          state_d = ARB_HOLD;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = ARB_SEND_WAIT;
        end
      end
      ARB_HOLD: begin
        if (req_vld[grant_q]) begin
          launch = 1'b1;
          cnt_d  = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          timeout_err_d = 1'b1;
          ptr_d         = next_ptr;
          state_d       = ARB_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (launch) begin
      tx_data_d             = req_data[int'(launch_idx)*DATA_WIDTH +: DATA_WIDTH];
      tx_vld_d              = 1'b1;
      req_rdy_d[launch_idx] = 1'b1;
      grant_d               = launch_idx;
      last_d                = req_last[launch_idx];
      state_d               = ARB_SEND_WAIT;
    end else begin
      tx_vld_d = 1'b0;
    end

    busy_d = (state_d != ARB_IDLE);
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= {GW{1'b0}};
      cnt_q         <= {CW{1'b0}};
      last_q        <= 1'b0;
      grant_q       <= {GW{1'b0}};
      tx_data_q     <= {DATA_WIDTH{1'b0}};
      tx_vld_q      <= 1'b0;
      req_rdy_q     <= {NUM_REQ{1'b0}};
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      tx_vld_q      <= tx_vld_d;
      req_rdy_q     <= req_rdy_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_rdy     = req_rdy_q;
  assign tx_data     = tx_data_q;
  assign tx_vld      = tx_vld_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester and UART models run on the
// falling edge, the test sequence runs just after the rising edge.
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct packed {
    logic [7:0] idx;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_vld;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_rdy;
  logic [DW-1:0]     tx_data;
  logic              tx_vld;
  logic              tx_rdy;
  logic [0:0]        grant;
  logic              busy;
  logic              timeout_err;

  exp_t       exp_q[$];
  logic [8:0] src_q[NR][$];
  int         countdown  = 0;
  int         uart_delay = 20;
  int         rdy_count  = 0;
  logic       stray_req  = 1'b0;
  int         n_checks   = 0;
  int         n_errors   = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_rdy     (req_rdy),
    .tx_data     (tx_data),
    .tx_vld      (tx_vld),
    .tx_rdy      (tx_rdy),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    exp_t e;
    e.idx  = 8'(r);
    e.data = d;
    src_q[r].push_back({l, d});
    exp_q.push_back(e);
  endtask

  // Requester sources, UART completion model and output scoreboard.
  initial begin
    logic [NR-1:0] oh;
    logic          rdy_n;
    exp_t          e;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    tx_rdy   = 1'b0;
    forever begin
      @(negedge clk);
      rdy_n = stray_req;
      if (rst) begin
        countdown = 0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
      end else begin
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) rdy_n = 1'b1;
        end
        if (tx_vld) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_tx", 32'd0, 32'd1);
          end else begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.idx[0]] = 1'b1;
            check_eq("tx_data", tx_data, e.data);
            check_eq("grant", grant, e.idx);
            check_eq("req_rdy", req_rdy, oh);
          end
          countdown = uart_delay;
        end else begin
          check_eq("rdy_without_tx", req_rdy, 0);
        end
        for (int i = 0; i < NR; i++)
          if (req_rdy[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          req_vld[i]          = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0][7:0];
          req_last[i]         = src_q[i][0][8];
        end else begin
          req_vld[i]          = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i]         = 1'b0;
        end
      end
      tx_rdy = rdy_n;
      if (rdy_n) rdy_count++;
    end
  end

  task automatic wait_rdy(input int n);
    bit done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (rdy_count >= n) begin done = 1'b1; break; end
    end
    if (!done) check_eq("wait_tx_rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy && countdown == 0 &&
          src_q[0].size() == 0 && src_q[1].size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic stray_pulse(input logic exp_busy);
    stray_req = 1'b1;
    @(posedge clk); #1;
    stray_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check_eq("stray_busy", busy, exp_busy);
      check_eq("stray_tx_vld", tx_vld, 0);
      check_eq("stray_req_rdy", req_rdy, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_vld", tx_vld, 0);
    check_eq("rst_req_rdy", req_rdy, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Single 3-byte packet from requester 0.
    base = rdy_count;
    send(0, 8'h41, 1'b0);
    send(0, 8'h42, 1'b0);
    send(0, 8'h43, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      wait_rdy(base + k);
      check_eq("busy_after_tx_rdy", busy, (k < 3) ? 1 : 0);
    end
    wait_idle();

    // Contention straight after reset: requester 0 keeps the packet.
    do_reset();
    send(0, 8'hA0, 1'b0);
    send(0, 8'hA1, 1'b1);
    send(1, 8'hB0, 1'b1);
    wait_idle();

    // Fairness: eight single-byte packets from each requester.
    uart_delay = 4;
    for (int p = 0; p < 8; p++) begin
      send(0, 8'(8'h10 + p), 1'b1);
      send(1, 8'(8'h20 + p), 1'b1);
    end
    wait_idle();
    uart_delay = 20;

    // Timeout: requester 1 stalls mid-packet, requester 0 waits.
    base = rdy_count;
    send(1, 8'h71, 1'b0);
    wait_rdy(base + 1);
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (k == 5) send(0, 8'h72, 1'b1);
      check_eq("timeout_err", timeout_err, (k == TO) ? 1 : 0);
      if (k < TO) check_eq("hold_blocks_other", tx_vld, 0);
      else        check_eq("busy_after_timeout", busy, 0);
    end
    @(posedge clk); #1;
    check_eq("timeout_err_one_cycle", timeout_err, 0);
    wait_idle();

    // Stray completions in IDLE and in HOLD.
    stray_pulse(1'b0);
    base = rdy_count;
    send(0, 8'h51, 1'b0);
    wait_rdy(base + 1);
    stray_pulse(1'b1);
    send(0, 8'h52, 1'b1);
    wait_idle();

    // Reset in SEND_WAIT while the pointer favours requester 1.
    send(1, 8'h61, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (busy) begin seen = 1'b1; break; end
    end
    if (!seen) check_eq("wait_busy_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_tx_vld", tx_vld, 0);
    check_eq("midrst_req_rdy", req_rdy, 0);
    check_eq("midrst_tx_data", tx_data, 0);
    check_eq("midrst_grant", grant, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    send(0, 8'hE0, 1'b1);
    send(1, 8'hF0, 1'b1);
    wait_idle();

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single PC-facing UART transmitter (8-bit controller with tx_data/tx_vld/tx_rdy) between several byte-stream sources, e.g. the BlueTooth response path and local status/debug reporters.
- Arbitration is packet-atomic and round-robin. Once a requester wins, it keeps the transmitter until it sends a byte flagged last, or until it stalls longer than a timeout.
- Sits between the requester FIFOs/state machines and the UART controller in the top-level command handler.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- DATA_WIDTH, 8, byte width; fixed to match the UART controller.
- IDLE_TIMEOUT, 1024, clk cycles a granted requester may stall mid-packet before its grant is revoked (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_vld  in  NUM_REQ  per-requester byte valid; held with data until req_rdy seen.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i uses bits [i*8 +: 8].
- req_last  in  NUM_REQ  byte is final of packet; qualified by req_vld.
- req_rdy  out  NUM_REQ  registered one-cycle accept pulse; requester advances on it.
- tx_data  out  DATA_WIDTH  byte to UART controller.
- tx_vld  out  1  one-cycle start pulse to UART controller.
- tx_rdy  in  1  one-cycle transmit-complete pulse from UART controller.
- grant  out  $clog2(NUM_REQ)  index of current/last owner.
- busy  out  1  high while any packet is owned (states SEND_WAIT, HOLD).
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst sampled high at a clk edge): state=IDLE; req_rdy=0, tx_vld=0, tx_data=0, grant=0, busy=0, timeout_err=0; rr pointer=0; timeout counter=0. Reset mid-transmission abandons the packet. The UART controller is reset by the same source.
- States: IDLE, SEND_WAIT, HOLD (2-bit encoding).
- IDLE:
  - If any req_vld is high, winner w is the first set bit searching upward from the rr pointer, with wrap.
  - Next edge: tx_data<=req_data[w], tx_vld<=1 for one cycle, req_rdy[w]<=1 for one cycle, grant<=w, last_flag<=req_last[w], busy<=1, go to SEND_WAIT.
  - Latency: req_vld at cycle n gives tx_vld and req_rdy at cycle n+1.
- SEND_WAIT:
  - All req_vld are ignored and no req_rdy is asserted.
  - On tx_rdy with last_flag=1: go to IDLE, rr pointer<=(grant+1) mod NUM_REQ, busy<=0.
  - On tx_rdy with last_flag=0: go to HOLD, clear the counter.
  - No timeout applies in SEND_WAIT.
- HOLD:
  - Only req_vld[grant] is considered; other requesters are blocked.
  - If req_vld[grant] is high: send exactly as in IDLE (same one-cycle latency), counter cleared, go to SEND_WAIT.
  - Otherwise the counter increments. When counter==IDLE_TIMEOUT-1: timeout_err pulses, rr pointer<=(grant+1) mod NUM_REQ, busy<=0, go to IDLE.
- tx_rdy arriving in IDLE or HOLD is ignored.
- req_last with req_vld low is ignored.
- Simultaneous requests in IDLE are resolved purely by the rr pointer. The just-served requester has lowest priority next time.
- Counter width: $clog2(IDLE_TIMEOUT+1); it saturates and never wraps.
- Back-to-back throughput: tx_rdy at cycle m with a waiting byte gives the next tx_vld at m+2 (one cycle for the state change, one for the registered launch).
- Exactly one req_rdy pulse per tx_vld pulse, always to the index on grant.

Decomposition:
- Shared package (cmd_pkg): state localparams ARB_IDLE/ARB_SEND_WAIT/ARB_HOLD, DATA_WIDTH=8 byte constant.
- Sub-module rr_picker: combinational, inputs req vector and pointer, outputs winner index and any_req.
- The FSM, counter and output registers stay in uart_tx_arbiter.

Test Plan:
- Single packet: req0 sends 0x41, 0x42, 0x43 (last on 0x43), tx_rdy returned 20 cycles after each tx_vld -> tx_data sequence 41,42,43; three req_rdy[0] pulses; grant=0; busy falls the cycle after the 3rd tx_rdy.
- Contention: req0 and req1 both assert in the same cycle after reset -> req0 is served first. While req0's 2-byte packet is in flight, req1 remains blocked and no req_rdy[1] is issued. req1 is granted after req0's last byte.
- Fairness: both requesters continuously send 1-byte packets for 8 packets -> grant alternates 0,1,0,1,...; no requester is served twice in a row.
- Timeout: IDLE_TIMEOUT=16; req1 sends a non-last byte then drops vld -> timeout_err pulses exactly 16 cycles after entering HOLD; state returns to IDLE; req0 pending is granted next.
- Stray completion: tx_rdy pulse injected in IDLE and in HOLD -> no state change, no tx_vld, no req_rdy.
- Reset mid-operation: rst asserted in SEND_WAIT -> the next cycle shows all outputs 0, grant=0, and rr pointer=0 (verified by req0 winning a subsequent tie).
